// File: rtl/dcsk_mod_top.sv
// DCSK modulator: turns 32-bit information words into a serial chip stream.
// Each bit is sent as SF reference chips from a 16-bit LFSR, then SF data chips.
// The data chips repeat the reference when the bit is 1 and invert it when the bit is 0.
//
// Handshake: a word is taken on any rising edge where In_Valid and In_Ready are both 1.
// In_Ready is high in IDLE, and also on the final chip of a frame so frames can run
// back-to-back. In_Valid may be held high across frames; In_Data, In_Valid and
// Spread_Factor_Sel are ignored at every other time.
//
// Mod_Valid/Mod_Data/Frame_Done form an output-only stream with no backpressure.
// Position registers (state, bit_cnt, chip_cnt) always describe the chip that is
// currently on Mod_Data. Each edge works out the next position, then registers
// the chip for that position.
module dcsk_mod_top #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          WORD_W    = 32
) (
  input  logic              Clk,
  input  logic              N_Rst,
  input  logic [WORD_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [1:0]        Spread_Factor_Sel,
  output logic              Mod_Data,
  output logic              Mod_Valid,
  output logic              Frame_Done,
  output logic [1:0]        Dbg_State
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REF  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [3:0]        sf_last_q, sf_last_d;
  logic [3:0]        chip_cnt_q, chip_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0]       ref_sr_q, ref_sr_d;
  logic              mod_data_q, mod_data_d;
  logic              mod_valid_q, mod_valid_d;
  logic              frame_done_q, frame_done_d;

  logic [15:0] lfsr_adv;
  logic        chip_last;
  logic        bit_last;
  logic        frame_last;
  logic        accept;
  logic [3:0]  sel_last;

  // Shared decode: LFSR step, terminal counts, handshake and SF decode
  always_comb begin
    lfsr_adv   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    chip_last  = (chip_cnt_q == sf_last_q);
    bit_last   = (bit_cnt_q == LAST_BIT);
    frame_last = (state_q == S_DATA) && chip_last && bit_last;
    In_Ready   = (state_q == S_IDLE) || frame_last;
    accept     = In_Valid && In_Ready;
    case (Spread_Factor_Sel)
      2'b00:   sel_last = 4'd1;
      2'b01:   sel_last = 4'd3;
      2'b10:   sel_last = 4'd7;
      default: sel_last = 4'd15;
    endcase
  end

  // Next chip position, then the registered chip value for that position
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    word_d       = word_q;
    sf_last_d    = sf_last_q;
    chip_cnt_d   = chip_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    ref_sr_d     = ref_sr_q;
    mod_data_d   = 1'b0;
    mod_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d     = In_Data;
          sf_last_d  = sel_last;
          bit_cnt_d  = '0;
          chip_cnt_d = '0;
          state_d    = S_REF;
        end
      end
      S_REF: begin
        if (chip_last) begin
          chip_cnt_d = '0;
          state_d    = S_DATA;
        end else begin
          chip_cnt_d = chip_cnt_q + 4'd1;
        end
      end
      S_DATA: begin
        if (!chip_last) begin
          chip_cnt_d = chip_cnt_q + 4'd1;
        end else if (!bit_last) begin
          word_d     = word_q << 1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          chip_cnt_d = '0;
          state_d    = S_REF;
        end else if (accept) begin
          word_d     = In_Data;
          sf_last_d  = sel_last;
          bit_cnt_d  = '0;
          chip_cnt_d = '0;
          state_d    = S_REF;
        end else begin
          chip_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The chip for the next position: fresh chaos in REF, the stored reference in DATA
    if (state_d == S_REF) begin
      mod_valid_d          = 1'b1;
      mod_data_d           = lfsr_q[0];
      ref_sr_d[chip_cnt_d] = lfsr_q[0];
      lfsr_d               = lfsr_adv;
    end else if (state_d == S_DATA) begin
      mod_valid_d = 1'b1;
      mod_data_d  = ref_sr_q[chip_cnt_d] ^ ~word_d[WORD_W-1];
    end
    frame_done_d = (state_d == S_DATA) && (chip_cnt_d == sf_last_d) &&
                   (bit_cnt_d == LAST_BIT);
  end

  // State, datapath and registered outputs; reset aborts any frame in progress
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      word_q       <= '0;
      sf_last_q    <= '0;
      chip_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      ref_sr_q     <= '0;
      mod_data_q   <= 1'b0;
      mod_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      word_q       <= word_d;
      sf_last_q    <= sf_last_d;
      chip_cnt_q   <= chip_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      ref_sr_q     <= ref_sr_d;
      mod_data_q   <= mod_data_d;
      mod_valid_q  <= mod_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Mod_Data   = mod_data_q;
  assign Mod_Valid  = mod_valid_q;
  assign Frame_Done = frame_done_q;
  assign Dbg_State  = state_q;

endmodule

// File: tb/tb_dcsk_mod_top.sv
// Bench for dcsk_mod_top: directed words, an expected-chip queue and a monitor.
module tb_dcsk_mod_top;

  logic        Clk = 1'b0;
  logic        N_Rst = 1'b0;
  logic [31:0] In_Data = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [1:0]  Spread_Factor_Sel = '0;
  logic        Mod_Data;
  logic        Mod_Valid;
  logic        Frame_Done;
  logic [1:0]  Dbg_State;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  dcsk_mod_top #(.LFSR_SEED(16'hACE1), .WORD_W(32)) dut (
    .Clk(Clk),
    .N_Rst(N_Rst),
    .In_Data(In_Data),
    .In_Valid(In_Valid),
    .In_Ready(In_Ready),
    .Spread_Factor_Sel(Spread_Factor_Sel),
    .Mod_Data(Mod_Data),
    .Mod_Valid(Mod_Valid),
    .Frame_Done(Frame_Done),
    .Dbg_State(Dbg_State)
  );

  // ---------------- scoreboard state ----------------
  logic [1:0]  exp_q[$];   // {frame_done, chip}
  int          len_q[$];   // expected valid cycles per frame
  logic        got_log[$]; // chips seen, for decode checks
  logic [15:0] m_lfsr = 16'hACE1;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          frame_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: the chips a word must produce, pushed at hand-off
  task automatic push_model(input logic [31:0] d, input logic [1:0] sel);
    int sf;
    logic [15:0] refc;
    logic fb;
    sf = 2 << sel;
    refc = '0;
    for (int b = 31; b >= 0; b--) begin
      for (int c = 0; c < sf; c++) begin
        refc[c] = m_lfsr[0];
        fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = {fb, m_lfsr[15:1]};
        exp_q.push_back({1'b0, refc[c]});
      end
      for (int c = 0; c < sf; c++) begin
        exp_q.push_back({(b == 0) && (c == sf - 1), d[b] ? refc[c] : ~refc[c]});
      end
    end
    len_q.push_back(64 * sf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic [1:0] sel);
    int n;
    @(negedge Clk);
    In_Data = d;
    Spread_Factor_Sel = sel;
    In_Valid = 1'b1;
    n = 0;
    while (!In_Ready && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    if (!In_Ready) begin
      check("ready_timeout", {31'b0, In_Ready}, 32'd1);
    end else begin
      push_model(d, sel);
    end
    @(posedge Clk);
  endtask

  task automatic idle_inputs();
    @(negedge Clk);
    In_Valid = 1'b0;
    In_Data = 32'h0BAD_F00D;
    Spread_Factor_Sel = 2'b11;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge Clk);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      len_q.delete();
    end
  endtask

  task automatic first8_check(input string name, input logic [7:0] want);
    logic [7:0] got;
    got = '0;
    check({name, "_count"}, {31'b0, got_log.size() >= 8}, 32'd1);
    if (got_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) got[7-i] = got_log[i];
      check(name, {24'b0, got}, {24'b0, want});
    end
  endtask

  // Correlates each data half with its reference half, as a receiver would
  task automatic decode_check(input string name, input logic [31:0] sent, input int sf);
    logic [31:0] dec;
    int base, match, bad;
    dec = '0;
    bad = 0;
    check({name, "_len"}, got_log.size(), 64 * sf);
    if (got_log.size() == 64 * sf) begin
      for (int b = 0; b < 32; b++) begin
        base = b * 2 * sf;
        match = 0;
        for (int c = 0; c < sf; c++) if (got_log[base+sf+c] === got_log[base+c]) match++;
        if (match == sf) dec[31-b] = 1'b1;
        else if (match != 0) bad++;
      end
      check({name, "_decode"}, dec, sent);
      check({name, "_partial_bits"}, bad, 32'd0);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (Mod_Valid) begin
        got_log.push_back(Mod_Data);
        frame_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_chip", {31'b0, Mod_Valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("chip_ready_done", {29'b0, In_Ready, Frame_Done, Mod_Data}, {29'b0, e[1], e[1], e[0]});
        end
        if (Frame_Done) begin
          if (len_q.size() != 0) check("frame_len", frame_cnt, len_q.pop_front());
          frame_cnt = 0;
        end
      end else begin
        check("idle_outputs", {29'b0, In_Ready, Frame_Done, Mod_Data}, 32'b100);
        check("no_gap", exp_q.size(), 32'd0);
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    #12;
    check("reset_outs", {28'b0, Mod_Valid, Mod_Data, Frame_Done, In_Ready}, 32'b0001);
    check("reset_state", {30'b0, Dbg_State}, 32'd0);
    repeat (3) @(negedge Clk);
    N_Rst = 1'b1;

    // Idle for 50 cycles with no request
    repeat (50) @(negedge Clk);

    // SF=2, single leading one: chips 1,0,1,0 then 0,0,1,1
    got_log.delete();
    send_word(32'h8000_0000, 2'b00);
    idle_inputs();
    wait_drain();
    first8_check("sf2_first8", 8'b1010_0011);
    decode_check("sf2_word", 32'h8000_0000, 2);

    // SF=16, all ones then all zeros
    got_log.delete();
    send_word(32'hFFFF_FFFF, 2'b11);
    idle_inputs();
    wait_drain();
    decode_check("sf16_ones", 32'hFFFF_FFFF, 16);
    got_log.delete();
    send_word(32'h0000_0000, 2'b11);
    idle_inputs();
    wait_drain();
    decode_check("sf16_zeros", 32'h0000_0000, 16);

    // Back-to-back frames with In_Valid held: SF=4 then SF=8
    got_log.delete();
    send_word(32'h1357_9BDF, 2'b01);
    send_word(32'h2468_ACE0, 2'b10);
    idle_inputs();
    wait_drain();
    check("b2b_total_len", got_log.size(), 256 + 512);

    // Reset in the middle of a frame, at chip 37
    got_log.delete();
    send_word(32'hDEAD_BEEF, 2'b00);
    idle_inputs();
    repeat (37) @(posedge Clk);
    #3;
    N_Rst = 1'b0;
    #1;
    check("midreset_outs", {28'b0, Mod_Valid, Mod_Data, Frame_Done, In_Ready}, 32'b0001);
    check("midreset_state", {30'b0, Dbg_State}, 32'd0);
    exp_q.delete();
    len_q.delete();
    frame_cnt = 0;
    m_lfsr = 16'hACE1;
    repeat (2) @(negedge Clk);
    N_Rst = 1'b1;

    // After reset the chaos sequence restarts at 1,0,0,0
    got_log.delete();
    send_word(32'hFFFF_FFFF, 2'b01);
    idle_inputs();
    wait_drain();
    first8_check("post_reset_first8", 8'b1000_1000);
    decode_check("post_reset_word", 32'hFFFF_FFFF, 4);

    // Mixed pattern at SF=8
    got_log.delete();
    send_word(32'hA5C3_0F96, 2'b10);
    idle_inputs();
    wait_drain();
    decode_check("sf8_mixed", 32'hA5C3_0F96, 8);

    repeat (5) @(negedge Clk);
    check("queues_empty", exp_q.size() + len_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dcsk_mod_top.md
Name: dcsk_mod_top

Overview:
DCSK modulator: the transmit-side counterpart of the receiver demodulator. It accepts a 32-bit information word through a valid/ready handshake and emits a serial 1-bit chaotic chip stream. For each information bit it sends a reference half of SF chaotic chips, then a data half of SF chips. The data half repeats the reference when the bit is 1 and inverts it when the bit is 0. Spread factor is selected with the same 2-bit encoding the receiver uses, so the two ends pair directly.

Parameters:
LFSR_SEED, 16'hACE1, chaos generator value after reset; must be non-zero.
WORD_W, 32, information bits per word; bit counter is $clog2(WORD_W) bits.

Ports:
Clk  input  1  system clock, rising edge.
N_Rst  input  1  asynchronous active-low reset.
In_Data  input  32  information word; transmitted MSB (bit 31) first.
In_Valid  input  1  In_Data and Spread_Factor_Sel are valid.
In_Ready  output  1  block can accept a word this cycle.
Spread_Factor_Sel  input  2  00->SF=2, 01->4, 10->8, 11->16; sampled only on acceptance.
Mod_Data  output  1  serial chip output.
Mod_Valid  output  1  Mod_Data holds a valid chip this cycle.
Frame_Done  output  1  one-cycle pulse on the last chip of a word.

Behaviour:
- Reset (N_Rst=0, async):
  - State=IDLE; LFSR=LFSR_SEED; counters and ref shift register = 0.
  - Mod_Data=0, Mod_Valid=0, Frame_Done=0, In_Ready=1.
- Chaos source:
  - 16-bit Fibonacci LFSR, right shift, fb = q[0]^q[2]^q[3]^q[5]; next = {fb, q[15:1]}.
  - Reference chip = q[0]. LFSR advances only on REF-phase chips.
  - LFSR is never reseeded except by reset; chaos continues across words.
- States:
  - IDLE: In_Ready=1. On In_Valid & In_Ready, latch the word into a shift register and latch SF. Go to REF with bit_cnt=0, chip_cnt=0.
  - REF: each cycle Mod_Data <= q[0] and ref_sr[chip_cnt] <= q[0]. When chip_cnt==SF-1, clear chip_cnt and go to DATA.
  - DATA: each cycle Mod_Data <= ref_sr[chip_cnt] ^ ~cur_bit, where cur_bit = current MSB of the word shift register. At chip_cnt==SF-1:
    - If bit_cnt < 31: shift the word left by 1, bit_cnt++, go to REF.
    - If bit_cnt == 31: assert Frame_Done on that chip.
- Last-chip handling: In_Ready=1 on the last chip of bit 31.
  - If In_Valid=1, accept the new word and go directly to REF: gapless back-to-back frames, new SF applies from the next chip.
  - Otherwise go to IDLE.
- Outputs are registered:
  - The accepting edge also registers the first reference chip, so Mod_Valid=1 starting the cycle after the handshake.
  - Mod_Valid=1 throughout REF/DATA; Mod_Valid=0 and Mod_Data=0 in IDLE.
- Latency and length:
  - First chip appears 1 cycle after acceptance.
  - A word lasts exactly 64*SF valid cycles (128/256/512/1024).
- In_Ready=0 during a frame except on its last chip. In_Data, In_Valid and Spread_Factor_Sel changes mid-frame are ignored.
- Reset asserted mid-frame aborts immediately to reset values; the partial word is discarded and not resumed.
- Counters: chip_cnt is 4 bits (max 15) and bit_cnt is 5 bits; no wrap beyond these terminal counts.

Test Plan:
- Reset, then check outputs; hold In_Valid=0 for 50 cycles -> Mod_Valid=0, In_Ready=1, Mod_Data=0, Frame_Done never pulses.
- SF_SEL=00, In_Data=32'h8000_0000, seed ACE1 -> first 8 chips are 1,0,1,0 (bit31=1), then 0,0,1,1 (bit30=0). Mod_Valid lasts 128 cycles; Frame_Done pulses on cycle 128.
- SF_SEL=11, In_Data=32'hFFFF_FFFF -> each data half equals its preceding 16 reference chips. Total 1024 valid cycles. Redo with 32'h0 -> each data half is the bitwise inverse.
- Two words held valid back-to-back (SF=4, then SF=8) -> no Mod_Valid gap at the boundary; second frame has 512 valid cycles; In_Ready pulses only on the last chip of each frame.
- Drive N_Rst low at chip 37 of a frame -> outputs go to 0 asynchronously. After release, a new word restarts the LFSR output sequence at 1,0,0,0.
- Loopback: feed Mod_Data/Mod_Valid into the receiver demodulator with matching Spread_Factor_Sel for 100 random words and SFs -> every received Out_Data equals the sent In_Data.
